// File: rtl/regfile_mp_scoreboard_pkg.sv
// Shared register-file types and defaults for the per-core RV32 integer register file.
package riscv_rf_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_AW       = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_AW-1:0]     reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: tracks destinations with an outstanding producer.
module rf_scoreboard
  import riscv_rf_pkg::*;
#(
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_WR   = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         issue_en,
  input  logic [AW-1:0]                issue_rd,
  input  logic                         flush,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]    waddr,
  output logic [NUM_REGS-1:0]          busy,
  output logic                         any_busy
);

  logic [NUM_REGS-1:0] busy_next;

  // Later assignments override earlier ones, so the order encodes flush > issue > writeback clear.
  always_comb begin
    busy_next = busy;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) begin
        busy_next[waddr[j]] = 1'b0;
      end
    end
    if (issue_en) begin
      busy_next[issue_rd] = 1'b1;
    end
    if (flush) begin
      busy_next = '0;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      any_busy <= 1'b0;
    end else begin
      busy     <= busy_next;
      any_busy <= |busy_next;
    end
  end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with same-cycle write bypass and a busy scoreboard.
module regfile_mp_scoreboard
  import riscv_rf_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_RD-1:0][AW-1:0]     raddr,
  output logic [NUM_RD-1:0][DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]             rbusy,
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]     waddr,
  input  logic [NUM_WR-1:0][DATA_W-1:0] wdata,
  input  logic                          issue_en,
  input  logic [AW-1:0]                 issue_rd,
  input  logic                          flush,
  output logic                          any_busy
);

  localparam bit BYP_EN = (BYPASS != 0);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             busy;
  logic [NUM_RD-1:0]               wr_hit;
  logic [NUM_RD-1:0][DATA_W-1:0]   fwd_data;

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .flush    (flush),
    .wr_en    (wr_en),
    .waddr    (waddr),
    .busy     (busy),
    .any_busy (any_busy)
  );

  // Ascending port order makes the highest-indexed write win on an address clash.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (waddr[j] != '0)) begin
          regs[waddr[j]] <= wdata[j];
        end
      end
    end
  end

  always_comb begin
    wr_hit   = '0;
    fwd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (waddr[j] == raddr[i])) begin
          wr_hit[i]   = 1'b1;
          fwd_data[i] = wdata[j];
        end
      end
    end
  end

  // A forwarded hit clears rbusy because the producer's data is already on the read port.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (raddr[i] == '0) begin
        rdata[i] = '0;
        rbusy[i] = 1'b0;
      end else if (BYP_EN && wr_hit[i]) begin
        rdata[i] = fwd_data[i];
        rbusy[i] = 1'b0;
      end else begin
        rdata[i] = regs[raddr[i]];
        rbusy[i] = busy[raddr[i]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed bench: a bypassing two-write-port instance alongside a non-bypassing single-port one.
module tb_regfile_mp_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;

  logic                   clk;
  logic                   reset;
  logic [1:0][AW-1:0]     raddr;
  logic [1:0]             wr_en;
  logic [1:0][AW-1:0]     waddr;
  logic [1:0][DW-1:0]     wdata;
  logic                   issue_en;
  logic [AW-1:0]          issue_rd;
  logic                   flush;

  logic [1:0][DW-1:0]     rdata_b;
  logic [1:0]             rbusy_b;
  logic                   any_busy_b;
  logic [1:0][DW-1:0]     rdata_n;
  logic [1:0]             rbusy_n;
  logic                   any_busy_n;

  int check_count;
  int pass_count;

  regfile_mp_scoreboard #(
    .DATA_W (DW), .NUM_REGS (32), .NUM_RD (2), .NUM_WR (2), .BYPASS (1)
  ) dut (
    .clk (clk), .reset (reset), .raddr (raddr), .rdata (rdata_b), .rbusy (rbusy_b),
    .wr_en (wr_en), .waddr (waddr), .wdata (wdata), .issue_en (issue_en),
    .issue_rd (issue_rd), .flush (flush), .any_busy (any_busy_b)
  );

  regfile_mp_scoreboard #(
    .DATA_W (DW), .NUM_REGS (32), .NUM_RD (2), .NUM_WR (1), .BYPASS (0)
  ) dut_nb (
    .clk (clk), .reset (reset), .raddr (raddr), .rdata (rdata_n), .rbusy (rbusy_n),
    .wr_en (wr_en[0:0]), .waddr (waddr[0:0]), .wdata (wdata[0:0]), .issue_en (issue_en),
    .issue_rd (issue_rd), .flush (flush), .any_busy (any_busy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we0, input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                               input logic we1, input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                               input logic ie, input logic [AW-1:0] ird, input logic fl);
    wr_en[0]  = we0;
    waddr[0]  = wa0;
    wdata[0]  = wd0;
    wr_en[1]  = we1;
    waddr[1]  = wa1;
    wdata[1]  = wd1;
    issue_en  = ie;
    issue_rd  = ird;
    flush     = fl;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    reset       = 1'b1;
    raddr[0]    = 5'd0;
    raddr[1]    = 5'd0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("reset_rdata0", rdata_b[0], 32'h0);
    checkOutput("reset_any_busy", {31'b0, any_busy_b}, 32'h0);

    // Same-cycle write/read of x1: bypassed vs stored value
    raddr[0] = 5'd1;
    applyStimulus(1'b1, 5'd1, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    #1;
    checkOutput("byp_x1_same_cycle", rdata_b[0], 32'hDEADBEEF);
    checkOutput("nobyp_x1_same_cycle", rdata_n[0], 32'h0);
    tick();
    idle();
    #1;
    checkOutput("byp_x1_next", rdata_b[0], 32'hDEADBEEF);
    checkOutput("nobyp_x1_next", rdata_n[0], 32'hDEADBEEF);

    // Writes to x0 on every port are dropped
    raddr[1] = 5'd0;
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0);
    #1;
    checkOutput("x0_same_cycle", rdata_b[1], 32'h0);
    checkOutput("x0_same_cycle_nb", rdata_n[1], 32'h0);
    tick();
    idle();
    #1;
    checkOutput("x0_after", rdata_b[1], 32'h0);
    checkOutput("x0_after_nb", rdata_n[1], 32'h0);
    checkOutput("x1_kept", rdata_b[0], 32'hDEADBEEF);

    // Both ports write x5; the higher port wins
    raddr[0] = 5'd5;
    applyStimulus(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 1'b0, 5'd0, 1'b0);
    #1;
    checkOutput("x5_bypass_prio", rdata_b[0], 32'h22);
    tick();
    idle();
    #1;
    checkOutput("x5_stored_prio", rdata_b[0], 32'h22);
    checkOutput("x5_nb_single_port", rdata_n[0], 32'h11);

    // Issue x7, then resolve it with a write
    raddr[0] = 5'd7;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
    #1;
    checkOutput("x7_busy_before_edge", {31'b0, rbusy_b[0]}, 32'h0);
    tick();
    idle();
    #1;
    checkOutput("x7_rbusy", {31'b0, rbusy_b[0]}, 32'h1);
    checkOutput("x7_any_busy", {31'b0, any_busy_b}, 32'h1);
    checkOutput("x7_rbusy_nb", {31'b0, rbusy_n[0]}, 32'h1);
    applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    #1;
    checkOutput("x7_rbusy_masked", {31'b0, rbusy_b[0]}, 32'h0);
    checkOutput("x7_rbusy_nb_unmasked", {31'b0, rbusy_n[0]}, 32'h1);
    checkOutput("x7_fwd_data", rdata_b[0], 32'h77);
    tick();
    idle();
    #1;
    checkOutput("x7_cleared", {31'b0, rbusy_b[0]}, 32'h0);
    checkOutput("x7_cleared_any", {31'b0, any_busy_b}, 32'h0);
    checkOutput("x7_cleared_nb", {31'b0, rbusy_n[0]}, 32'h0);

    // Issue and write x7 together: newer producer keeps it busy
    applyStimulus(1'b1, 5'd7, 32'h78, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
    tick();
    idle();
    #1;
    checkOutput("x7_issue_write_busy", {31'b0, rbusy_b[0]}, 32'h1);
    checkOutput("x7_issue_write_any", {31'b0, any_busy_n}, 32'h1);
    checkOutput("x7_issue_write_data", rdata_n[0], 32'h78);
    applyStimulus(1'b1, 5'd7, 32'h79, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();
    idle();

    // Several outstanding issues, then flush alongside a new issue
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
    tick();
    idle();
    raddr[0] = 5'd3;
    raddr[1] = 5'd9;
    #1;
    checkOutput("x3_busy", {31'b0, rbusy_b[0]}, 32'h1);
    checkOutput("x9_busy", {31'b0, rbusy_b[1]}, 32'h1);
    checkOutput("multi_any_busy", {31'b0, any_busy_b}, 32'h1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b1);
    tick();
    idle();
    raddr[1] = 5'd10;
    #1;
    checkOutput("flush_x3", {31'b0, rbusy_b[0]}, 32'h0);
    checkOutput("flush_x10", {31'b0, rbusy_b[1]}, 32'h0);
    checkOutput("flush_any_busy", {31'b0, any_busy_b}, 32'h0);
    checkOutput("flush_any_busy_nb", {31'b0, any_busy_n}, 32'h0);
    raddr[0] = 5'd5;
    raddr[1] = 5'd1;
    #1;
    checkOutput("flush_keeps_x5", rdata_b[0], 32'h22);
    checkOutput("flush_keeps_x1", rdata_b[1], 32'hDEADBEEF);

    // Asynchronous reset between edges clears data and busy state
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0);
    tick();
    idle();
    #1;
    checkOutput("pre_reset_busy", {31'b0, rbusy_b[1]}, 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_rdata", rdata_b[1], 32'h0);
    checkOutput("async_reset_rdata_nb", rdata_n[0], 32'h0);
    checkOutput("async_reset_rbusy", {31'b0, rbusy_b[1]}, 32'h0);
    checkOutput("async_reset_any", {31'b0, any_busy_b}, 32'h0);

    // Writes and issues presented while reset is held are lost
    applyStimulus(1'b1, 5'd5, 32'hABCD, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0);
    tick();
    idle();
    reset = 1'b0;
    #1;
    checkOutput("reset_drops_write", rdata_n[0], 32'h0);
    checkOutput("reset_drops_issue", {31'b0, any_busy_b}, 32'h0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
